perf_cycle_counter: RTL and testbench

Parametrised cycle-measurement unit. It times the active-low `done` interval of a unit under test (for example, a sorter or a multiplier). It keeps a live count, the last completed measurement, the maximum measurement and a run count. A selectable, prescaled window of these is driven onto a display bus. It adds saturation, statistics clear and a measurement-valid strobe.

---
 rtl/perf_cycle_counter_if.sv | 42 ++++
 rtl/perf_cycle_counter.sv | 137 +++++++++++++
 tb/tb_perf_cycle_counter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/perf_cycle_counter_if.sv
// Display/control bus of perf_cycle_counter.
//   done       : UUT status, low while an operation is in progress
//   clr        : synchronous clear of last/max/runs/overflow
//   sel        : display select (0 live, 1 last, 2 max, 3 runs)
//   cycles     : selected, prescaled value
//   busy       : measurement in progress (registered)
//   meas_valid : one-cycle strobe after a measurement is captured
//   overflow   : sticky saturation flag
// The slave modport is the counter; the master modport is whoever drives done/clr/sel.
interface perf_cycle_counter_if #(
  parameter int unsigned OUT_W = 16
) ();

  logic             done;
  logic             clr;
  logic [1:0]       sel;
  logic [OUT_W-1:0] cycles;
  logic             busy;
  logic             meas_valid;
  logic             overflow;

  modport master (
    output done,
    output clr,
    output sel,
    input  cycles,
    input  busy,
    input  meas_valid,
    input  overflow
  );

  modport slave (
    input  done,
    input  clr,
    input  sel,
    output cycles,
    output busy,
    output meas_valid,
    output overflow
  );

endinterface

// File: rtl/perf_cycle_counter.sv
// Cycle-measurement unit: times the active-low interval of a UUT's done line.
// Keeps a live count, the last completed measurement, the maximum measurement and
// a run count, and drives a selectable, prescaled view of them onto the bus.
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   bus  : perf_cycle_counter_if.slave (done, clr, sel in; cycles, busy,
//          meas_valid, overflow out)
// SHIFT + OUT_W must not exceed CNT_W.
module perf_cycle_counter #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 8,
  parameter int unsigned RUN_W = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  perf_cycle_counter_if.slave   bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [RUN_W-1:0] RunMax = '1;

  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [RUN_W-1:0] runs_q, runs_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic start_ev, count_ev, end_ev;
  logic cnt_sat, runs_sat;
  logic ovf_set;

  // Edge classification of done against its registered copy. Start and end are
  // mutually exclusive by construction.
  assign start_ev = done_q & ~bus.done;
  assign count_ev = ~done_q & ~bus.done;
  assign end_ev   = ~done_q & bus.done;

  assign cnt_sat  = (cnt_q == CntMax);
  assign runs_sat = (runs_q == RunMax);

  always_comb begin
    done_d  = bus.done;
    cnt_d   = cnt_q;
    last_d  = last_q;
    max_d   = max_q;
    runs_d  = runs_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    ovf_set = 1'b0;

    // Live counter is untouched by clr; the first low cycle counts as 1.
    if (start_ev) begin
      cnt_d = CNT_W'(1);
    end else if (count_ev) begin
      if (cnt_sat) begin
        ovf_set = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (bus.clr) begin
      // clr wins over a coincident capture and over a coincident saturation.
      last_d = '0;
      max_d  = '0;
      runs_d = '0;
      ovf_d  = 1'b0;
    end else begin
      if (end_ev) begin
        last_d  = cnt_q;
        valid_d = 1'b1;
        if (cnt_q > max_q) begin
          max_d = cnt_q;
        end
        if (runs_sat) begin
          ovf_set = 1'b1;
        end else begin
          runs_d = runs_q + RUN_W'(1);
        end
      end
      ovf_d = ovf_q | ovf_set;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_q  <= 1'b1;
      cnt_q   <= '0;
      last_q  <= '0;
      max_q   <= '0;
      runs_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      max_q   <= max_d;
      runs_q  <= runs_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  // Run count is shown unshifted, zero-extended or truncated to the display width.
  logic [OUT_W-1:0] runs_view;
  if (RUN_W >= OUT_W) begin : g_runs_trunc
    assign runs_view = runs_q[OUT_W-1:0];
  end else begin : g_runs_ext
    assign runs_view = {{(OUT_W - RUN_W){1'b0}}, runs_q};
  end

  logic [OUT_W-1:0] cycles_mux;
  always_comb begin
    cycles_mux = '0;
    unique case (bus.sel)
      2'd0:    cycles_mux = cnt_q[SHIFT +: OUT_W];
      2'd1:    cycles_mux = last_q[SHIFT +: OUT_W];
      2'd2:    cycles_mux = max_q[SHIFT +: OUT_W];
      2'd3:    cycles_mux = runs_view;
      default: cycles_mux = '0;
    endcase
  end

  assign bus.cycles     = cycles_mux;
  assign bus.busy       = ~done_q;
  assign bus.meas_valid = valid_q;
  assign bus.overflow   = ovf_q;

  // Bits of last/runs outside the display window are intentionally not observed.
  logic unused_bits;
  assign unused_bits = ^{last_q, runs_q};

endmodule

// File: tb/tb_perf_cycle_counter.sv
// Bench for perf_cycle_counter: a default instance (CNT_W=32, OUT_W=16, SHIFT=8)
// and a small saturating instance (CNT_W=10, OUT_W=10, SHIFT=0). Expected captures
// are queued as each run is issued; a monitor pops one on every meas_valid strobe.
module tb_perf_cycle_counter;

  logic clk;
  logic rstn;

  int unsigned errors = 0;
  int unsigned checks = 0;

  int unsigned exp0_q[$];
  int unsigned exp1_q[$];
  int unsigned pulses0 = 0, pulses1 = 0;
  int unsigned busy0 = 0, busy1 = 0;

  perf_cycle_counter_if #(.OUT_W(16)) bus0 ();
  perf_cycle_counter_if #(.OUT_W(10)) bus1 ();

  perf_cycle_counter #(
    .CNT_W(32),
    .OUT_W(16),
    .SHIFT(8),
    .RUN_W(16)
  ) dut0 (
    .clk (clk),
    .rstn(rstn),
    .bus (bus0)
  );

  perf_cycle_counter #(
    .CNT_W(10),
    .OUT_W(10),
    .SHIFT(0),
    .RUN_W(16)
  ) dut1 (
    .clk (clk),
    .rstn(rstn),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard monitors: one capture expectation is consumed per strobe.
  always @(negedge clk) begin
    if (rstn && bus0.meas_valid) begin
      pulses0++;
      if (exp0_q.size() == 0) begin
        chk("d0_unexpected_strobe", 32'(bus0.cycles) + 1, 0);
      end else begin
        chk("d0_capture", 32'(bus0.cycles), exp0_q.pop_front());
      end
    end
    if (bus0.busy) busy0++;
  end

  always @(negedge clk) begin
    if (rstn && bus1.meas_valid) begin
      pulses1++;
      if (exp1_q.size() == 0) begin
        chk("d1_unexpected_strobe", 32'(bus1.cycles) + 1, 0);
      end else begin
        chk("d1_capture", 32'(bus1.cycles), exp1_q.pop_front());
      end
    end
    if (bus1.busy) busy1++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic view0(input string nm, input int s, input int unsigned exp);
    bus0.sel = 2'(s);
    #1;
    chk(nm, 32'(bus0.cycles), exp);
  endtask

  task automatic view1(input string nm, input int s, input int unsigned exp);
    bus1.sel = 2'(s);
    #1;
    chk(nm, 32'(bus1.cycles), exp);
  endtask

  // done low for exactly n rising edges, then high.
  task automatic run0(input int n);
    tick(1);
    bus0.done = 1'b0;
    tick(n);
    bus0.done = 1'b1;
  endtask

  task automatic run1(input int n);
    tick(1);
    bus1.done = 1'b0;
    tick(n);
    bus1.done = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned b, p;
    rstn      = 1'b0;
    bus0.done = 1'b1; bus0.clr = 1'b0; bus0.sel = 2'd0;
    bus1.done = 1'b1; bus1.clr = 1'b0; bus1.sel = 2'd0;
    #12;
    for (int s = 0; s < 4; s++) view0("rst_d0_cycles", s, 0);
    chk("rst_d0_busy", 32'(bus0.busy), 0);
    chk("rst_d0_valid", 32'(bus0.meas_valid), 0);
    chk("rst_d0_ovf", 32'(bus0.overflow), 0);
    tick(1);
    rstn = 1'b1;
    tick(2);
    chk("idle_d0_busy", 32'(bus0.busy), 0);

    // 1000-cycle run on the default instance.
    bus0.sel = 2'd1;
    exp0_q.push_back(3);
    b = busy0; p = pulses0;
    run0(1000);
    tick(3);
    chk("t1_busy_len", busy0 - b, 1000);
    chk("t1_pulses", pulses0 - p, 1);
    view0("t1_live", 0, 3);
    view0("t1_last", 1, 3);
    view0("t1_max", 2, 3);
    view0("t1_runs", 3, 1);

    // Shorter run keeps max; longer run raises it.
    bus0.sel = 2'd1;
    exp0_q.push_back(1);
    run0(300);
    tick(3);
    view0("t2_max", 2, 3);
    view0("t2_runs", 3, 2);
    bus0.sel = 2'd1;
    exp0_q.push_back(10);
    run0(2560);
    tick(3);
    view0("t2b_max", 2, 10);
    view0("t2b_last", 1, 10);
    view0("t2b_runs", 3, 3);

    // Saturation on the 10-bit instance, then clr.
    bus1.sel = 2'd1;
    exp1_q.push_back(1023);
    tick(1);
    bus1.done = 1'b0;
    tick(1100);
    view1("t3_live_sat", 0, 1023);
    chk("t3_ovf_set", 32'(bus1.overflow), 1);
    chk("t3_busy", 32'(bus1.busy), 1);
    bus1.sel  = 2'd1;
    bus1.done = 1'b1;
    tick(3);
    view1("t3_last", 1, 1023);
    bus1.clr = 1'b1;
    tick(1);
    bus1.clr = 1'b0;
    chk("t3_ovf_clr", 32'(bus1.overflow), 0);
    view1("t3_last_clr", 1, 0);
    view1("t3_max_clr", 2, 0);
    view1("t3_runs_clr", 3, 0);
    view1("t3_live_kept", 0, 1023);

    // Single-cycle low pulse.
    bus1.sel = 2'd1;
    exp1_q.push_back(1);
    b = busy1; p = pulses1;
    run1(1);
    tick(3);
    chk("t4_busy_len", busy1 - b, 1);
    chk("t4_pulses", pulses1 - p, 1);
    view1("t4_runs", 3, 1);
    view1("t4_last", 1, 1);

    // clr coincident with the end edge discards the capture.
    p = pulses1;
    tick(1);
    bus1.done = 1'b0;
    tick(50);
    bus1.done = 1'b1;
    bus1.clr  = 1'b1;
    tick(1);
    bus1.clr = 1'b0;
    tick(2);
    chk("t5_pulses", pulses1 - p, 0);
    view1("t5_last", 1, 0);
    view1("t5_runs", 3, 0);
    view1("t5_live", 0, 50);

    // Reset mid-run with done held low through release.
    tick(1);
    bus1.done = 1'b0;
    tick(500);
    rstn = 1'b0;
    #1;
    for (int s = 0; s < 4; s++) view1("t6_rst_d1_cycles", s, 0);
    for (int s = 0; s < 4; s++) view0("t6_rst_d0_cycles", s, 0);
    chk("t6_rst_busy", 32'(bus1.busy), 0);
    chk("t6_rst_ovf", 32'(bus1.overflow), 0);
    chk("t6_rst_valid", 32'(bus1.meas_valid), 0);
    tick(2);
    rstn = 1'b1;
    tick(1);
    view1("t6_restart", 0, 1);
    chk("t6_busy", 32'(bus1.busy), 1);
    bus1.sel = 2'd1;
    exp1_q.push_back(200);
    tick(199);
    bus1.done = 1'b1;
    tick(3);
    view1("t6_last", 1, 200);
    view1("t6_max", 2, 200);
    view1("t6_runs", 3, 1);

    tick(2);
    chk("sb0_drained", exp0_q.size(), 0);
    chk("sb1_drained", exp1_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
